// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX issue stage: ALU opcodes and control-bundle bit positions.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_MUL  = 4'b1001,
    ALU_DIV  = 4'b1010,
    ALU_REM  = 4'b1011,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam int CTRL_REG_WRITE   = 0;
  localparam int CTRL_MEM_READ    = 1;
  localparam int CTRL_MEM_WRITE   = 2;
  localparam int CTRL_BRANCH      = 3;
  localparam int CTRL_ALU_SRC_IMM = 4;
  localparam int CTRL_ALU_SRC_PC  = 5;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-way operand forward select: EX/MEM result, then MEM/WB data, then the stored value.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_rs,
  input  logic [XLEN-1:0] i_reg_data,
  input  logic            i_exm_we,
  input  logic [RA_W-1:0] i_exm_rd,
  input  logic [XLEN-1:0] i_exm_data,
  input  logic            i_wb_we,
  input  logic [RA_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_data
);

  logic w_exm_hit;
  logic w_wb_hit;

  // x0 is hard-wired zero, so a write targeting it must never be forwarded
  assign w_exm_hit = i_exm_we && (i_exm_rd != '0) && (i_exm_rd == i_rs);
  assign w_wb_hit  = i_wb_we  && (i_wb_rd  != '0) && (i_wb_rd  == i_rs);

  assign o_data = w_exm_hit ? i_exm_data :
                  w_wb_hit  ? i_wb_data  : i_reg_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection, flush and hold.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic [2:0]        id_funct3,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              exm_reg_write,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [RA_W-1:0]   ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   ex_store_data
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [RA_W-1:0]   r_rs1;
  logic [RA_W-1:0]   r_rs2;
  logic [RA_W-1:0]   r_rd;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [3:0]        r_alu_op;
  logic [2:0]        r_funct3;
  logic [CTRL_W-1:0] r_ctrl;

  logic [CTRL_W-1:0] w_ctrl;
  logic [XLEN-1:0]   w_fwd1;
  logic [XLEN-1:0]   w_fwd2;
  logic [XLEN-1:0]   w_cap1;
  logic [XLEN-1:0]   w_cap2;
  logic              w_hz;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd1 (
    .i_rs       (r_rs1),
    .i_reg_data (r_rs1_data),
    .i_exm_we   (exm_reg_write),
    .i_exm_rd   (exm_rd),
    .i_exm_data (exm_result),
    .i_wb_we    (wb_reg_write),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .o_data     (w_fwd1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd2 (
    .i_rs       (r_rs2),
    .i_reg_data (r_rs2_data),
    .i_exm_we   (exm_reg_write),
    .i_exm_rd   (exm_rd),
    .i_exm_data (exm_result),
    .i_wb_we    (wb_reg_write),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .o_data     (w_fwd2)
  );

  // Register file is written the same cycle it is read, so catch the WB value on capture
  assign w_cap1 = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
  assign w_cap2 = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;

  assign w_hz = r_valid && r_ctrl[CTRL_MEM_READ] && (r_rd != '0) &&
                ((r_rd == id_rs1) || (r_rd == id_rs2)) && id_valid;

  assign id_stall = ~flush && (ex_hold || w_hz);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_alu_op   <= ALU_ADD;
      r_funct3   <= '0;
      r_ctrl     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (ex_hold) begin
      // Latch forwarded operands now; the producers move on while EX is frozen
      r_rs1_data <= w_fwd1;
      r_rs2_data <= w_fwd2;
    end else if (w_hz) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_rs1_data <= w_cap1;
      r_rs2_data <= w_cap2;
      r_imm      <= id_imm;
      r_alu_op   <= id_alu_op;
      r_funct3   <= id_funct3;
      r_ctrl     <= id_valid ? id_ctrl : '0;
    end
  end

  assign w_ctrl = r_valid ? r_ctrl : '0;

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_rd         = r_rd;
  assign ex_funct3     = r_funct3;
  assign ex_ctrl       = w_ctrl;
  assign alu_op        = r_alu_op;
  assign alu_a         = w_ctrl[CTRL_ALU_SRC_PC]  ? r_pc  : w_fwd1;
  assign alu_b         = w_ctrl[CTRL_ALU_SRC_IMM] ? r_imm : w_fwd2;
  assign ex_store_data = w_fwd2;

endmodule
